// File: rtl/vit_wb_sequencer_if.sv
// Wishbone slave bus bundle for the ViT sequencer register window.
interface vit_wb_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    wbs_stb_i;
    logic                    wbs_cyc_i;
    logic                    wbs_we_i;
    logic [DATA_WIDTH/8-1:0] wbs_sel_i;
    logic [31:0]             wbs_adr_i;
    logic [DATA_WIDTH-1:0]   wbs_dat_i;
    logic                    wbs_ack_o;
    logic [DATA_WIDTH-1:0]   wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/vit_wb_sequencer.sv
// Wishbone-programmed job sequencer for the ViT core: start pulse, raster
// patch-coordinate issue over valid/ready, done wait and level interrupt.
//
// state       | meaning
// S_IDLE      | no job; waits for START with legal geometry
// S_START     | core_start_o high for this single cycle
// S_ISSUE     | patch_valid_o high, coordinates advance on each accept
// S_WAIT_DONE | all patches accepted, waiting for core_done_i
module vit_wb_sequencer #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          MAX_IMAGE_SIZE = 512,
    parameter int          PATCH_SIZE     = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    vit_wb_sequencer_if.slave wbs,
    output logic              core_start_o,
    input  logic              core_done_i,
    output logic              patch_valid_o,
    input  logic              patch_ready_i,
    output logic [9:0]        patch_x_o,
    output logic [9:0]        patch_y_o,
    output logic              irq_o
);

    localparam int          PW      = $clog2(PATCH_SIZE);
    localparam logic [10:0] MAX_L   = 11'(MAX_IMAGE_SIZE);
    localparam logic [10:0] PATCH_L = 11'(PATCH_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_START, S_ISSUE, S_WAIT_DONE} state_t;

    state_t                state_q;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] dat_q, rdata_d;
    logic                  irq_en_q;
    logic [9:0]            img_w_q, img_h_q;
    logic                  done_q, err_q, irq_q;
    logic                  core_start_q, valid_q;
    logic [9:0]            x_q, y_q;
    logic [10:0]           cnt_q;

    logic       hit, req, wr, busy;
    logic [7:0] offset;
    logic       wr_ctrl, wr_stat, start_cmd, abort_cmd, done_clr, err_clr;
    logic [10:0] x_nxt, y_nxt;
    logic       row_end, last_patch, geom_ok;

    assign hit    = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req    = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q & hit;
    assign wr     = req & wbs.wbs_we_i;
    assign offset = wbs.wbs_adr_i[7:0];
    assign busy   = (state_q != S_IDLE);
    assign ack_d  = req;

    assign wr_ctrl   = wr && (offset == 8'h00) && wbs.wbs_sel_i[0];
    assign wr_stat   = wr && (offset == 8'h04) && wbs.wbs_sel_i[0];
    assign abort_cmd = wr_ctrl & wbs.wbs_dat_i[2];
    assign start_cmd = wr_ctrl & wbs.wbs_dat_i[0] & ~wbs.wbs_dat_i[2];
    assign done_clr  = wr_stat & wbs.wbs_dat_i[1];
    assign err_clr   = wr_stat & wbs.wbs_dat_i[2];

    // 11-bit sums so a 512-wide image never wraps the compare
    assign x_nxt      = {1'b0, x_q} + PATCH_L;
    assign y_nxt      = {1'b0, y_q} + PATCH_L;
    assign row_end    = (x_nxt >= {1'b0, img_w_q});
    assign last_patch = row_end && (y_nxt >= {1'b0, img_h_q});

    assign geom_ok = (img_w_q != 10'd0) && ({1'b0, img_w_q} <= MAX_L) && (img_w_q[PW-1:0] == '0) &&
                     (img_h_q != 10'd0) && ({1'b0, img_h_q} <= MAX_L) && (img_h_q[PW-1:0] == '0);

    always_comb begin
        rdata_d = '0;
        if (req && !wbs.wbs_we_i) begin
            case (offset)
                8'h00:   rdata_d[1]    = irq_en_q;
                8'h04:   rdata_d[2:0]  = {err_q, done_q, busy};
                8'h08:   rdata_d[9:0]  = img_w_q;
                8'h0C:   rdata_d[9:0]  = img_h_q;
                8'h10:   rdata_d[10:0] = cnt_q;
                default: rdata_d       = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_en_q <= 1'b0;
            img_w_q  <= '0;
            img_h_q  <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= rdata_d;
            if (wr_ctrl) irq_en_q <= wbs.wbs_dat_i[1];
            // geometry is frozen for the duration of a job
            if (wr && !busy && offset == 8'h08) begin
                if (wbs.wbs_sel_i[0]) img_w_q[7:0] <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) img_w_q[9:8] <= wbs.wbs_dat_i[9:8];
            end
            if (wr && !busy && offset == 8'h0C) begin
                if (wbs.wbs_sel_i[0]) img_h_q[7:0] <= wbs.wbs_dat_i[7:0];
                if (wbs.wbs_sel_i[1]) img_h_q[9:8] <= wbs.wbs_dat_i[9:8];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            irq_q        <= 1'b0;
            core_start_q <= 1'b0;
            valid_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
        end else begin
            irq_q <= done_q & irq_en_q;
            if (done_clr) done_q <= 1'b0;
            if (err_clr)  err_q  <= 1'b0;
            if (abort_cmd && busy) begin
                state_q      <= S_IDLE;
                core_start_q <= 1'b0;
                valid_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_cmd) begin
                            if (!geom_ok) begin
                                err_q <= 1'b1;
                            end else begin
                                cnt_q        <= '0;
                                x_q          <= '0;
                                y_q          <= '0;
                                core_start_q <= 1'b1;
                                state_q      <= S_START;
                            end
                        end
                    end
                    S_START: begin
                        core_start_q <= 1'b0;
                        valid_q      <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (patch_ready_i) begin
                            cnt_q <= cnt_q + 11'd1;
                            if (last_patch) begin
                                valid_q <= 1'b0;
                                state_q <= S_WAIT_DONE;
                            end else if (!row_end) begin
                                x_q <= x_nxt[9:0];
                            end else begin
                                x_q <= '0;
                                y_q <= y_nxt[9:0];
                            end
                        end
                    end
                    S_WAIT_DONE: begin
                        if (core_done_i) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign core_start_o  = core_start_q;
    assign patch_valid_o = valid_q;
    assign patch_x_o     = x_q;
    assign patch_y_o     = y_q;
    assign irq_o         = irq_q;

    logic unused_bits;
    assign unused_bits = ^{wbs.wbs_dat_i[DATA_WIDTH-1:10], wbs.wbs_sel_i[DATA_WIDTH/8-1:2]};

endmodule

// File: tb/tb_vit_wb_sequencer.sv
// Randomized bench for vit_wb_sequencer against a raster-order patch model.
module tb_vit_wb_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [7:0]  R_CTRL = 8'h00, R_STAT = 8'h04, R_W = 8'h08, R_H = 8'h0C, R_CNT = 8'h10;

    logic       clk, rst;
    logic       core_start, core_done, patch_valid, patch_ready, irq;
    logic [9:0] patch_x, patch_y;

    vit_wb_sequencer_if bus ();

    vit_wb_sequencer dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs           (bus),
        .core_start_o  (core_start),
        .core_done_i   (core_done),
        .patch_valid_o (patch_valid),
        .patch_ready_i (patch_ready),
        .patch_x_o     (patch_x),
        .patch_y_o     (patch_y),
        .irq_o         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int         acc_x[$], acc_y[$], acc_t[$];
    int         n_start, n_valid, cyc_n, rdy_mode, pat_idx, lim;
    bit         prev_start, prev_hold;
    logic [9:0] hold_x, hold_y;

    initial begin
        n_start = 0; n_valid = 0; cyc_n = 0; rdy_mode = 4; pat_idx = 0; lim = 0;
        prev_start = 0; prev_hold = 0; hold_x = '0; hold_y = '0;
    end

    // observes the patch port on every clock edge
    always @(posedge clk) begin
        cyc_n++;
        if (rst) begin
            prev_start = 0;
            prev_hold  = 0;
        end else begin
            if (prev_start) begin
                chk("start_width", 32'(core_start), 32'd0);
                chk("valid_after_start", 32'(patch_valid), 32'd1);
            end
            if (prev_hold && patch_valid) begin
                chk("x_hold", 32'(patch_x), 32'(hold_x));
                chk("y_hold", 32'(patch_y), 32'(hold_y));
            end
            if (core_start) n_start++;
            if (patch_valid) n_valid++;
            if (patch_valid && patch_ready) begin
                acc_x.push_back(int'(patch_x));
                acc_y.push_back(int'(patch_y));
                acc_t.push_back(cyc_n);
            end
            prev_start = core_start;
            prev_hold  = patch_valid && !patch_ready;
            hold_x     = patch_x;
            hold_y     = patch_y;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: patch_ready = 1'b1;
            1: begin
                patch_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                pat_idx++;
            end
            2: patch_ready = 1'($urandom_range(0, 1));
            3: patch_ready = (acc_x.size() < lim);
            default: patch_ready = 1'b0;
        endcase
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        int n;
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.wbs_ack_o && n < 5);
        chk("wb_ack_latency", 32'(n), 32'd1);
        rd = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        tick();
        chk("wb_ack_width", 32'(bus.wbs_ack_o), 32'd0);
        chk("wb_dat_idle", bus.wbs_dat_o, 32'd0);
    endtask

    task automatic wb_wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] rd;
        wb_xfer(BASE | 32'(off), 1'b1, dat, sel, rd);
    endtask

    task automatic wb_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        wb_xfer(BASE | 32'(off), 1'b0, 32'd0, 4'hF, rd);
        chk(tag, rd, exp);
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic run_job(input int w, input int h, input int mode, input bit ien);
        int ex[$], ey[$];
        int n, k, m;
        for (int y = 0; y < h; y += 16)
            for (int x = 0; x < w; x += 16) begin
                ex.push_back(x);
                ey.push_back(y);
            end
        n = ex.size();
        wb_wr(R_W, 32'(w));
        wb_wr(R_H, 32'(h));
        acc_x.delete(); acc_y.delete(); acc_t.delete();
        n_start = 0;
        pat_idx = 0;
        rdy_mode = mode;
        wb_wr(R_CTRL, ien ? 32'h3 : 32'h1);
        k = 0;
        while (acc_x.size() < n && k < 8 * n + 40) begin
            tick();
            k++;
        end
        rdy_mode = 4;
        chk("job_accepts", 32'(acc_x.size()), 32'(n));
        m = (acc_x.size() < n) ? acc_x.size() : n;
        for (int i = 0; i < m; i++) begin
            chk("patch_x", 32'(acc_x[i]), 32'(ex[i]));
            chk("patch_y", 32'(acc_y[i]), 32'(ey[i]));
        end
        if (mode == 0 && m == n) chk("back_to_back", 32'(acc_t[n-1] - acc_t[0]), 32'(n - 1));
        tick(5);
        chk("valid_in_wait", 32'(patch_valid), 32'd0);
        pulse_done();
        chk("irq_lag", 32'(irq), 32'd0);
        tick();
        chk("irq_after_done", 32'(irq), 32'(ien));
        wb_chk("status_done", R_STAT, 32'h2);
        wb_chk("patch_cnt", R_CNT, 32'(n));
        chk("start_pulses", 32'(n_start), 32'd1);
        wb_wr(R_STAT, 32'h2);
        chk("irq_cleared", 32'(irq), 32'd0);
        wb_chk("status_clr", R_STAT, 32'h0);
    endtask

    initial begin
        int err_w[3];
        int k;
        bit seen;
        rst = 1'b1;
        core_done = 1'b0;
        patch_ready = 1'b0;
        bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = '0;   bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
        tick(3);
        chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        chk("rst_dat", bus.wbs_dat_o, 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_valid", 32'(patch_valid), 32'd0);
        chk("rst_xy", 32'({patch_x, patch_y}), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        tick();
        wb_chk("rst_status", R_STAT, 32'h0);
        wb_chk("rst_cnt", R_CNT, 32'h0);
        wb_chk("rst_img_w", R_W, 32'h0);

        run_job(32, 32, 0, 1'b1);
        run_job(32, 32, 1, 1'b1);

        err_w[0] = 20; err_w[1] = 0; err_w[2] = 528;
        foreach (err_w[i]) begin
            wb_wr(R_W, 32'(err_w[i]));
            wb_wr(R_H, 32'd32);
            n_start = 0;
            n_valid = 0;
            wb_wr(R_CTRL, 32'h1);
            tick(3);
            wb_chk("bad_geom_status", R_STAT, 32'h4);
            chk("bad_geom_start", 32'(n_start), 32'd0);
            chk("bad_geom_valid", 32'(n_valid), 32'd0);
            wb_wr(R_STAT, 32'h4);
            wb_chk("err_clr", R_STAT, 32'h0);
        end

        wb_wr(R_W, 32'd32);
        n_start = 0;
        wb_wr(R_CTRL, 32'h5);
        tick(3);
        chk("start_abort_word", 32'(n_start), 32'd0);
        wb_chk("start_abort_status", R_STAT, 32'h0);

        wb_wr(R_W, 32'd512);
        wb_wr(R_H, 32'd512);
        acc_x.delete(); acc_y.delete(); acc_t.delete();
        lim = 10;
        rdy_mode = 3;
        wb_wr(R_CTRL, 32'h3);
        k = 0;
        while (acc_x.size() < 10 && k < 200) begin
            tick();
            k++;
        end
        tick(3);
        wb_chk("abort_busy", R_STAT, 32'h1);
        wb_wr(R_W, 32'd16);
        wb_wr(R_CTRL, 32'h4);
        chk("abort_valid", 32'(patch_valid), 32'd0);
        chk("abort_accepts", 32'(acc_x.size()), 32'd10);
        wb_chk("abort_status", R_STAT, 32'h0);
        wb_chk("abort_cnt", R_CNT, 32'd10);
        wb_chk("busy_w_ignored", R_W, 32'd512);
        pulse_done();
        tick(2);
        wb_chk("late_done_ignored", R_STAT, 32'h0);
        chk("late_done_irq", 32'(irq), 32'd0);
        rdy_mode = 4;

        wb_chk("hole_read", 8'h80, 32'h0);
        wb_wr(R_CNT, 32'h7FF);
        wb_chk("cnt_ro", R_CNT, 32'd10);
        wb_wr(R_W, 32'h3FF, 4'b0001);
        wb_chk("sel_byte0", R_W, 32'h2FF);
        wb_wr(R_W, 32'h100, 4'b0010);
        wb_chk("sel_byte1", R_W, 32'h1FF);
        bus.wbs_adr_i = 32'h3000_0100;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            if (bus.wbs_ack_o) seen = 1;
        end
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        chk("nohit_ack", 32'(seen), 32'd0);

        for (int j = 0; j < 6; j++)
            run_job(16 * int'($urandom_range(1, 6)), 16 * int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

        run_job(512, 512, 0, 1'b1);

        wb_wr(R_W, 32'd64);
        wb_wr(R_H, 32'd64);
        acc_x.delete(); acc_y.delete(); acc_t.delete();
        rdy_mode = 2;
        wb_wr(R_CTRL, 32'h3);
        k = 0;
        while (acc_x.size() < 3 && k < 100) begin
            tick();
            k++;
        end
        chk("pre_reset_accepts", 32'(acc_x.size() >= 3), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_start", 32'(core_start), 32'd0);
        chk("mid_rst_valid", 32'(patch_valid), 32'd0);
        chk("mid_rst_xy", 32'({patch_x, patch_y}), 32'd0);
        chk("mid_rst_irq", 32'(irq), 32'd0);
        chk("mid_rst_ack", 32'(bus.wbs_ack_o), 32'd0);
        rdy_mode = 0;
        tick();
        rst = 1'b0;
        n_start = 0;
        n_valid = 0;
        tick(5);
        chk("post_rst_start", 32'(n_start), 32'd0);
        chk("post_rst_valid", 32'(n_valid), 32'd0);
        wb_chk("post_rst_status", R_STAT, 32'h0);
        wb_chk("post_rst_cnt", R_CNT, 32'h0);
        wb_chk("post_rst_img_w", R_W, 32'h0);
        rdy_mode = 4;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/vit_wb_sequencer.md
# vit_wb_sequencer

Wishbone-mapped control and scheduling block for the VisionTransformer datapath inside the user project wrapper. Firmware on the management SoC uses it to program the image geometry and start a job. The block then pulses the core start, issues patch coordinates in raster order over a valid/ready handshake, waits for the core's done, and raises a user interrupt. It is the only sequencer of the core; the core never self-starts.

## Interface
- DATA_WIDTH, 32, Wishbone data width.
- MAX_IMAGE_SIZE, 512, maximum legal image width/height in pixels.
- PATCH_SIZE, 16, patch edge in pixels; power of two.
- BASE_ADDR, 32'h3000_0000, register window base; 256-byte window.

Ports:
- wb_clk_i  in  1  single clock; all logic rises on it.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_stb_i / wbs_cyc_i / wbs_we_i  in  1 each  Wishbone strobe, cycle, write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- core_start_o  out  1  one-cycle job start pulse to the core.
- core_done_i  in  1  core finished job; level or pulse.
- patch_valid_o  out  1  patch coordinate valid.
- patch_ready_i  in  1  core accepts patch.
- patch_x_o, patch_y_o  out  10 each  top-left pixel of the current patch.
- irq_o  out  1  level interrupt.

## Operation
- Decode: a hit requires adr[31:8]==BASE_ADDR[31:8]. Offset is adr[7:0]. Non-hits are never acked.
- Register map:
  - 0x00 CTRL: bit0 START (write-1 pulse, reads 0); bit1 IRQ_EN (RW); bit2 ABORT (write-1 pulse, reads 0).
  - 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-clear); bit2 ERR (sticky, write-1-clear).
  - 0x08 IMG_W, bits[9:0], RW.
  - 0x0C IMG_H, bits[9:0], RW.
  - 0x10 PATCH_CNT: RO count of accepted patches in the current or last job.
  - Other offsets read 0; writes are ignored but acked.
- Writes honour wbs_sel_i per byte. Writes to IMG_W/IMG_H while BUSY are ignored (still acked).
- FSM states: IDLE, START, ISSUE, WAIT_DONE.
- IDLE + START written:
  - Error case: if IMG_W or IMG_H is 0, exceeds MAX_IMAGE_SIZE, or is not a multiple of PATCH_SIZE, set ERR and stay IDLE.
  - Otherwise clear PATCH_CNT, set x=y=0, go to START.
- START: core_start_o=1 for exactly one cycle, then go to ISSUE.
- ISSUE:
  - patch_valid_o=1. x/y are held stable until patch_ready_i is sampled high.
  - On accept: PATCH_CNT+1. If x+PATCH_SIZE<IMG_W, x+=PATCH_SIZE; else x=0 and y+=PATCH_SIZE.
  - Accept of the last patch (x=IMG_W-PATCH_SIZE, y=IMG_H-PATCH_SIZE) goes to WAIT_DONE.
- WAIT_DONE: on core_done_i=1, set DONE and go to IDLE. core_done_i is ignored in all other states.
- BUSY = state≠IDLE.
- START while BUSY is ignored.
- ABORT in any busy state: next state IDLE, patch_valid_o drops next cycle, DONE and ERR unchanged. ABORT in IDLE does nothing.
- If START and ABORT are written in the same word, ABORT wins.
- irq_o = DONE & IRQ_EN, registered.
- Arithmetic: x/y are 10-bit; the sum is computed 11-bit for the compare, so there is no wrap at 512. Patches per job = (W/PATCH_SIZE)·(H/PATCH_SIZE), maximum 1024. PATCH_CNT is 11 bits, zero-extended on read.

## Timing
- Reset values: wbs_ack_o=0, wbs_dat_o=0, core_start_o=0, patch_valid_o=0, patch_x_o=patch_y_o=0, irq_o=0. Registers clear to 0; state=IDLE.
- Wishbone:
  - wbs_ack_o rises the cycle after a hit with stb&cyc&~ack, and is one cycle wide. Every transfer takes 2 cycles; there are no back-to-back acks.
  - Read data is valid with ack and returns to 0 otherwise.
  - Register updates and START take effect on the ack edge.
- Latencies:
  - START ack edge → core_start_o high the next cycle.
  - patch_valid_o rises the cycle after core_start_o.
  - Accepting handshake → new x/y the next cycle. One patch per cycle is possible with ready held high.
  - core_done_i edge → BUSY=0 and DONE=1 the next cycle; irq_o one cycle later.
- A DONE W1C in the same cycle as a new DONE set: set wins.
- Reset mid-job: everything returns to reset values asynchronously, with no start pulse or valid glitch.

## Test plan
- Config W=32, H=32, IRQ_EN=1, START; ready always 1 → one start pulse; patches (0,0),(16,0),(0,16),(16,16) on 4 consecutive cycles; PATCH_CNT=4; core_done after 5 cycles → STATUS=0x2, irq_o=1; W1C DONE → irq_o=0.
- Same job with ready toggled 1-0-0-1 → x/y held stable while ready=0; the 4 coordinates are unchanged and PATCH_CNT=4.
- W=20 (or 0, or 528) then START → ERR=1, BUSY=0, no core_start_o, no valid.
- W=H=512, ABORT after 10 accepts → BUSY=0 next cycle, valid drops, PATCH_CNT=10, DONE=0; a later core_done_i is ignored.
- Assert wb_rst_i during ISSUE → all outputs 0 immediately; after release STATUS=0 and PATCH_CNT=0.
- Read 0x80, write to 0x10, access outside BASE_ADDR → first two acked in 2 cycles with 0 / no change; the third is never acked.
